// File: rtl/line_raster_pkg.sv
// Shared types and width helpers for the line rasteriser.
// Optional abort support is controlled by the LINE_RASTER_ABORT_EN macro in line_raster_gen.
package line_raster_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Step direction encoding held in the sx/sy registers
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    // Error accumulator width: holds dx + dy and every intermediate update
    function automatic int err_w(input int coord_w);
        return coord_w + 2;
    endfunction

    // Doubled-error width: 2*err without overflow
    function automatic int e2_w(input int coord_w);
        return coord_w + 3;
    endfunction

endpackage

// File: rtl/bresenham_step.sv
// Combinational Bresenham step: next point and next error from the current
// point, error and the line's constant deltas / directions.
module bresenham_step
    import line_raster_pkg::*;
#(
    parameter int COORD_W = 8,
    localparam int ERR_W = err_w(COORD_W)
) (
    input  logic [COORD_W-1:0]      x_i,
    input  logic [COORD_W-1:0]      y_i,
    input  logic signed [ERR_W-1:0] err_i,
    input  logic [COORD_W:0]        dx_i,
    input  logic [COORD_W:0]        ady_i,
    input  logic                    sx_i,
    input  logic                    sy_i,
    output logic [COORD_W-1:0]      x_o,
    output logic [COORD_W-1:0]      y_o,
    output logic signed [ERR_W-1:0] err_o
);

    localparam int E2_W = e2_w(COORD_W);

    logic signed [E2_W-1:0] e2;
    logic signed [E2_W-1:0] dx_s;
    logic signed [E2_W-1:0] dy_s;
    logic signed [E2_W-1:0] acc;
    logic                   step_x;
    logic                   step_y;

    // Both axis decisions use the same e2; both updates apply in one step
    always_comb begin
        e2     = {err_i, 1'b0};
        dx_s   = {2'b00, dx_i};
        dy_s   = -{2'b00, ady_i};
        step_x = (e2 >= dy_s);
        step_y = (e2 <= dx_s);
        acc    = {err_i[ERR_W-1], err_i};
        x_o    = x_i;
        y_o    = y_i;
        if (step_x) begin
            acc = acc + dy_s;
            x_o = (sx_i == DIR_NEG) ? x_i - COORD_W'(1) : x_i + COORD_W'(1);
        end
        if (step_y) begin
            acc = acc + dx_s;
            y_o = (sy_i == DIR_NEG) ? y_i - COORD_W'(1) : y_i + COORD_W'(1);
        end
        err_o = acc[ERR_W-1:0];
    end

endmodule

// File: rtl/line_raster_gen.sv
// Bresenham line rasteriser, all octants, start/busy/done command handshake and
// valid/ready pixel stream with a last-pixel marker.
// Define LINE_RASTER_ABORT_EN to add an abort input that cancels a line in progress.
module line_raster_gen
    import line_raster_pkg::*;
#(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
`ifdef LINE_RASTER_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last
);

    localparam int ERR_W = err_w(COORD_W);

    state_e                   state_q;
    logic [COORD_W-1:0]       x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W:0]         dx_q, ady_q;
    logic                     sx_q, sy_q;
    logic signed [ERR_W-1:0]  err_q;
    logic [COORD_W-1:0]       px_q, py_q;
    logic                     busy_q, done_q, vld_q, last_q;

    logic [COORD_W-1:0]       x_d, y_d;
    logic signed [ERR_W-1:0]  err_d;
    logic [COORD_W:0]         dx_d, ady_d;
    logic                     sx_d, sy_d;
    logic                     abort_w;

`ifdef LINE_RASTER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Line constants derived from the latched endpoints, consumed in SETUP
    always_comb begin
        dx_d  = '0;
        ady_d = '0;
        sx_d  = DIR_NEG;
        sy_d  = DIR_NEG;
        if (x1_q > x0_q) begin
            dx_d = {1'b0, x1_q - x0_q};
            sx_d = DIR_POS;
        end else begin
            dx_d = {1'b0, x0_q - x1_q};
        end
        if (y1_q > y0_q) begin
            ady_d = {1'b0, y1_q - y0_q};
            sy_d  = DIR_POS;
        end else begin
            ady_d = {1'b0, y0_q - y1_q};
        end
    end

    bresenham_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .x_i   (px_q),
        .y_i   (py_q),
        .err_i (err_q),
        .dx_i  (dx_q),
        .ady_i (ady_q),
        .sx_i  (sx_q),
        .sy_i  (sy_q),
        .x_o   (x_d),
        .y_o   (y_d),
        .err_o (err_d)
    );

    // Control FSM with registered outputs; abort wins over a pixel handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            dx_q    <= '0;
            ady_q   <= '0;
            sx_q    <= DIR_POS;
            sy_q    <= DIR_POS;
            err_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (abort_w) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        dx_q    <= dx_d;
                        ady_q   <= ady_d;
                        sx_q    <= sx_d;
                        sy_q    <= sy_d;
                        err_q   <= ERR_W'({1'b0, dx_d}) - ERR_W'({1'b0, ady_d});
                        px_q    <= x0_q;
                        py_q    <= y0_q;
                        last_q  <= (x0_q == x1_q) && (y0_q == y1_q);
                        vld_q   <= 1'b1;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    if (abort_w) begin
                        vld_q   <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (vld_q && pix_ready) begin
                        if (last_q) begin
                            vld_q   <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            px_q   <= x_d;
                            py_q   <= y_d;
                            err_q  <= err_d;
                            last_q <= (x_d == x1_q) && (y_d == y1_q);
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_valid = vld_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_last  = last_q;

endmodule

// File: tb/tb_line_raster_gen.sv
// Self-checking bench for line_raster_gen: directed and random lines against an
// integer Bresenham reference, with varied output backpressure.
module tb_line_raster_gen;

    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] x0, y0, x1, y1;
    logic          busy, done, pix_valid, pix_ready, pix_last;
    logic [CW-1:0] pix_x, pix_y;
`ifdef LINE_RASTER_ABORT_EN
    logic          abort = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    line_raster_gen #(.COORD_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
`ifdef LINE_RASTER_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // rmode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready.
    // poke: pulse start mid-line and during the done cycle; both must be ignored.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int rmode, input bit poke);
        int qx[$];
        int qy[$];
        int mdx, mdy, msx, msy, merr, mx, my, me2;
        int exp_cnt, got_n, cyc, pi;
        bit fin, held, rdy, exp_last;
        logic [CW-1:0] hx, hy;
        logic hlast;

        // Reference pixel list straight from the integer Bresenham rules
        mdx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        mdy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        msx  = (ax1 > ax0) ? 1 : -1;
        msy  = (ay1 > ay0) ? 1 : -1;
        mx   = ax0;
        my   = ay0;
        merr = mdx + mdy;
        for (int k = 0; k < 2048; k++) begin
            qx.push_back(mx);
            qy.push_back(my);
            if (mx == ax1 && my == ay1) break;
            me2 = 2 * merr;
            if (me2 >= mdy) begin merr += mdy; mx += msx; end
            if (me2 <= mdx) begin merr += mdx; my += msy; end
        end
        exp_cnt = ((mdx > -mdy) ? mdx : -mdy) + 1;

        @(negedge clk);
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
        chk("busy_setup", busy, 1);
        chk("vld_setup", pix_valid, 0);
        @(negedge clk);
        chk("vld_first", pix_valid, 1);

        held = 0; got_n = 0; fin = 0; cyc = 0; pi = 0;
        hx = '0; hy = '0; hlast = 1'b0;
        while (!fin && cyc < 4000) begin
            if (held) begin
                chk("hold_x", pix_x, hx);
                chk("hold_y", pix_y, hy);
                chk("hold_last", pix_last, hlast);
            end
            if (pix_valid !== 1'b1) begin
                chk("vld_draw", pix_valid, 1);
                fin = 1;
            end else begin
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = (pi % 3 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                pi++;
                pix_ready = rdy;
                if (poke && cyc == 2) begin
                    x0 = CW'($urandom); y0 = CW'($urandom);
                    x1 = CW'($urandom); y1 = CW'($urandom);
                    start = 1'b1;
                end
                if (rdy) begin
                    held = 0;
                    if (qx.size() == 0) begin
                        chk("extra_pixel", 1, 0);
                        fin = 1;
                    end else begin
                        exp_last = (qx.size() == 1);
                        chk("pix_x", pix_x, qx[0]);
                        chk("pix_y", pix_y, qy[0]);
                        chk("pix_last", pix_last, exp_last);
                        chk("busy_draw", busy, 1);
                        void'(qx.pop_front());
                        void'(qy.pop_front());
                        got_n++;
                        if (exp_last) fin = 1;
                    end
                end else begin
                    held  = 1;
                    hx    = pix_x;
                    hy    = pix_y;
                    hlast = pix_last;
                end
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (!fin) chk("timeout", 1, 0);
        pix_ready = 1'b0;
        chk("pix_count", got_n, exp_cnt);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("vld_done", pix_valid, 0);
        if (poke) begin
            x0 = CW'($urandom); y0 = CW'($urandom);
            x1 = CW'($urandom); y1 = CW'($urandom);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_single", done, 0);
        chk("busy_idle", busy, 0);
        chk("vld_idle", pix_valid, 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; pix_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vld", pix_valid, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_x", pix_x, 0);
        chk("rst_y", pix_y, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed lines
        run_line(0, 0, 5, 0, 0, 0);
        run_line(0, 0, 5, 2, 0, 0);
        run_line(3, 7, 1, 0, 0, 0);
        run_line(4, 4, 4, 4, 0, 0);
        run_line(0, 0, 3, 3, 1, 1);
        run_line(2, 9, 2, 1, 2, 0);
        run_line(0, 0, 255, 255, 0, 0);
        run_line(255, 0, 0, 255, 2, 1);
        run_line(255, 3, 0, 0, 0, 0);
        run_line(10, 200, 11, 0, 1, 0);

        // Reset asserted mid-line
        @(negedge clk);
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pix_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_vld", pix_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vld", pix_valid, 0);
        chk("mid_rst_x", pix_x, 0);
        chk("mid_rst_y", pix_y, 0);
        chk("mid_rst_done", done, 0);
        pix_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_line(0, 0, 9, 3, 0, 0);

        // Random lines with random backpressure modes
        for (int i = 0; i < 12; i++) begin
            run_line($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255),
                     i % 3, (i % 4) == 0);
        end
        for (int i = 0; i < 6; i++) begin
            run_line($urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7), 2, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_raster_gen.md
Name: line_raster_gen

Overview:
- Parametrised Bresenham line rasteriser covering all octants. It accepts endpoint pairs through a start/busy/done handshake.
- Emits one pixel coordinate per accepted beat on a valid/ready stream, with a last-pixel marker.
- Successor to the fixed 4-bit free-running stepper: generic coordinate width, explicit command handshake, output backpressure, and correct handling of steep and negative-slope lines.
- Sits between the coordinate source (IO pins or a command sequencer) and the framebuffer/pixel writer.

Parameters:
- COORD_W, 8, bit width of each unsigned coordinate (legal range 2..16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- x0  in  COORD_W  start x, unsigned.
- y0  in  COORD_W  start y, unsigned.
- x1  in  COORD_W  end x, unsigned.
- y1  in  COORD_W  end y, unsigned.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  single-cycle pulse after the last pixel is accepted.
- pix_valid  out  1  pix_x/pix_y/pix_last hold a valid pixel.
- pix_ready  in  1  downstream accepts the pixel when high together with pix_valid.
- pix_x  out  COORD_W  current pixel x.
- pix_y  out  COORD_W  current pixel y.
- pix_last  out  1  current pixel equals (x1,y1).

Behaviour:
- Reset is asynchronous on rst_n low and applies immediately regardless of state:
  - state = IDLE; busy = 0, done = 0, pix_valid = 0, pix_last = 0.
  - pix_x = 0, pix_y = 0; all internal registers = 0.
- FSM states: IDLE, SETUP, DRAW, FINISH.
- IDLE:
  - start = 1 latches x0/y0/x1/y1 into internal registers and moves to SETUP.
  - Endpoint inputs are don't-care at all other times.
- SETUP (1 cycle):
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx = +1 if x1 > x0, else -1; sy = +1 if y1 > y0, else -1.
  - err = dx + dy; pix_x = x0; pix_y = y0. Go to DRAW.
- DRAW:
  - pix_valid = 1; pix_last = (pix_x==x1 && pix_y==y1).
  - Outputs hold stable while pix_valid && !pix_ready.
  - On handshake with pix_last = 0, compute e2 = 2*err, then apply both updates in the same cycle:
    - if e2 >= dy: err += dy, x += sx;
    - if e2 <= dx: err += dx, y += sy.
  - On handshake with pix_last = 1: go to FINISH, drop pix_valid.
- FINISH (1 cycle): done = 1, busy = 0, then IDLE.
- busy is high in SETUP and DRAW. start is ignored whenever the state is not IDLE.
- Latency:
  - First pix_valid appears 2 cycles after the start cycle.
  - Throughput is 1 pixel/cycle with pix_ready held high.
  - Pixel count = max(dx,|dy|)+1.
- Width rules:
  - dx and |dy| are COORD_W+1 bits.
  - err is signed COORD_W+2 bits; e2 is signed COORD_W+3 bits; no overflow for any endpoints.
  - Coordinates never leave the bounding box of the two endpoints, so no wrap-around.
- Degenerate cases:
  - x0==x1 and y0==y1: exactly one pixel, pix_last = 1.
  - Horizontal, vertical and 45° lines: no special path; they fall out of the general update.
- Back-to-back: start may be asserted in the same cycle done pulses. It is accepted only once IDLE is reached, i.e. the cycle after.

Optional Feature:
- Macro LINE_RASTER_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort = 1 in SETUP or DRAW returns the FSM to IDLE on the next edge.
  - pix_valid and busy drop; done is NOT pulsed.
  - abort in IDLE/FINISH has no effect; abort has priority over a simultaneous pixel handshake.
- When undefined: no abort port; a line always runs to completion (only rst_n stops it).

Decomposition:
- Package line_raster_pkg:
  - state enum (IDLE, SETUP, DRAW, FINISH);
  - localparam helpers ERR_W = COORD_W+2 and E2_W = COORD_W+3, as functions of COORD_W;
  - step direction constants.
- Sub-module bresenham_step: purely combinational next-point/next-err calculation from (x, y, err, dx, dy, sx, sy).
- The FSM, handshake and registers stay in line_raster_gen.

Test Plan:
- Horizontal (0,0)->(5,0), pix_ready = 1 -> 6 pixels x = 0..5, y = 0; pix_last only on (5,0); done 1 cycle after.
- Shallow (0,0)->(5,2) -> sequence (0,0),(1,0),(2,1),(3,1),(4,2),(5,2).
- Steep negative (3,7)->(1,0) -> sequence (3,7),(3,6),(2,5),(2,4),(2,3),(2,2),(1,1),(1,0); 8 pixels.
- Single point (4,4)->(4,4) -> one pixel with pix_last = 1, then done pulse.
- Backpressure: pix_ready toggled 1,0,0,1... on (0,0)->(3,3) -> outputs stable while not ready; sequence (0,0),(1,1),(2,2),(3,3); start pulsed mid-line is ignored.
- rst_n low mid-DRAW -> immediately busy = 0, pix_valid = 0, pix_x = pix_y = 0; a new start after release draws a full line.
